// File: rtl/itch_msg_builder.sv
// itch_msg_builder: serializes ITCH 5.0 Add / Delete / Executed events into a
// packetized byte stream. Define ITCH_LEN_PREFIX_EN for 2-byte length prefixes.
module itch_msg_builder #(
    parameter int MAX_PKT_BYTES = 1400,
    parameter int IPG_CYCLES    = 12
) (
    input  logic        clkIn,
    input  logic        rstIn,
    input  logic        addValidIn,
    input  logic        delValidIn,
    input  logic        execValidIn,
    output logic        readyOut,
    input  logic [15:0] locateIn,
    input  logic [15:0] trackNumIn,
    input  logic [47:0] timeStampIn,
    input  logic [63:0] refNumIn,
    input  logic        buySellIn,
    input  logic [31:0] sharesIn,
    input  logic [63:0] stockIn,
    input  logic [31:0] priceIn,
    input  logic [63:0] matchNumIn,
    output logic [7:0]  dataOut,
    output logic        dataValidOut,
    output logic        multiReqOut
);

`ifdef ITCH_LEN_PREFIX_EN
    localparam int PFX = 2;
`else
    localparam int PFX = 0;
`endif
    localparam int MSG_W = 8 * (36 + PFX);
    localparam logic [5:0]  ADD_LEN  = 6'(36 + PFX);
    localparam logic [5:0]  DEL_LEN  = 6'(19 + PFX);
    localparam logic [5:0]  EXE_LEN  = 6'(31 + PFX);
    localparam logic [11:0] MAX_B    = 12'(MAX_PKT_BYTES);
    localparam logic [15:0] GAP_LAST = 16'(IPG_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t           state, state_nxt;
    logic [MSG_W-1:0] shreg, msg;
    logic [MSG_W-1:0] add_vec, del_vec, exe_vec;
    logic [287:0]     add_body;
    logic [151:0]     del_body;
    logic [247:0]     exe_body;
    logic [5:0]       cnt, len, req_len;
    logic [10:0]      pkt;
    logic [15:0]      gcnt;
    logic             pending, last, accept, multi, fits, gap_done;

    assign last     = (cnt == len - 6'd1);
    assign readyOut = (state == IDLE) || ((state == SEND) && last);
    assign accept   = readyOut && (addValidIn || delValidIn || execValidIn);
    assign multi    = (addValidIn && delValidIn) || (addValidIn && execValidIn)
                   || (delValidIn && execValidIn);
    assign gap_done = (gcnt == GAP_LAST);
    assign fits     = ({1'b0, pkt} + 12'd1 + {6'd0, req_len}) <= MAX_B;

    assign add_body = {8'h41, locateIn, trackNumIn, timeStampIn, refNumIn,
                       (buySellIn ? 8'h42 : 8'h53), sharesIn, stockIn, priceIn};
    assign del_body = {8'h44, locateIn, trackNumIn, timeStampIn, refNumIn};
    assign exe_body = {8'h45, locateIn, trackNumIn, timeStampIn, refNumIn,
                       sharesIn, matchNumIn};

`ifdef ITCH_LEN_PREFIX_EN
    assign add_vec = {16'h0024, add_body};
    assign del_vec = {16'h0013, del_body, 136'd0};
    assign exe_vec = {16'h001F, exe_body, 40'd0};
`else
    assign add_vec = add_body;
    assign del_vec = {del_body, 136'd0};
    assign exe_vec = {exe_body, 40'd0};
`endif

    // Pick the winning request (Add > Delete > Executed) and its length.
    always_comb begin
        msg     = exe_vec;
        req_len = EXE_LEN;
        if (addValidIn) begin
            msg     = add_vec;
            req_len = ADD_LEN;
        end else if (delValidIn) begin
            msg     = del_vec;
            req_len = DEL_LEN;
        end
    end

    // State register.
    always_ff @(posedge clkIn) begin
        if (rstIn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: chain, close packet into a gap, or return to idle.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = SEND;
            SEND: if (last) state_nxt = (accept && fits) ? SEND : GAP;
            GAP:  if (gap_done) state_nxt = pending ? SEND : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: shift bytes out MSB-first, track packet fill and gap timing.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            shreg        <= '0;
            len          <= '0;
            cnt          <= '0;
            pkt          <= '0;
            gcnt         <= '0;
            pending      <= 1'b0;
            dataOut      <= 8'h00;
            dataValidOut <= 1'b0;
            multiReqOut  <= 1'b0;
        end else begin
            dataOut      <= 8'h00;
            dataValidOut <= 1'b0;
            multiReqOut  <= accept && multi;
            gcnt         <= '0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        shreg <= msg;
                        len   <= req_len;
                        cnt   <= '0;
                        pkt   <= '0;
                    end
                end
                SEND: begin
                    dataOut      <= shreg[MSG_W-1 -: 8];
                    dataValidOut <= 1'b1;
                    shreg        <= shreg << 8;
                    cnt          <= cnt + 6'd1;
                    pkt          <= pkt + 11'd1;
                    if (last) begin
                        pending <= accept && !fits;
                        if (accept) begin
                            shreg <= msg;
                            len   <= req_len;
                            cnt   <= '0;
                        end
                        if (!accept || !fits) pkt <= '0;
                    end
                end
                GAP: begin
                    gcnt <= gcnt + 16'd1;
                    if (gap_done) pending <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_itch_msg_builder.sv
// tb_itch_msg_builder: randomized and directed checks of itch_msg_builder
// against a byte-queue reference model of the framed message stream.
module tb_itch_msg_builder;

`ifdef ITCH_LEN_PREFIX_EN
    localparam int PFX = 2;
`else
    localparam int PFX = 0;
`endif
    localparam int MAXP = 1400;
    localparam int IPG  = 12;

    logic        clkIn = 1'b0;
    logic        rstIn = 1'b1;
    logic        addValidIn = 1'b0, delValidIn = 1'b0, execValidIn = 1'b0;
    logic        readyOut;
    logic [15:0] locateIn = '0, trackNumIn = '0;
    logic [47:0] timeStampIn = '0;
    logic [63:0] refNumIn = '0, stockIn = '0, matchNumIn = '0;
    logic        buySellIn = 1'b0;
    logic [31:0] sharesIn = '0, priceIn = '0;
    logic [7:0]  dataOut;
    logic        dataValidOut, multiReqOut;

    itch_msg_builder #(.MAX_PKT_BYTES(MAXP), .IPG_CYCLES(IPG)) dut (
        .clkIn(clkIn), .rstIn(rstIn),
        .addValidIn(addValidIn), .delValidIn(delValidIn),
        .execValidIn(execValidIn), .readyOut(readyOut),
        .locateIn(locateIn), .trackNumIn(trackNumIn),
        .timeStampIn(timeStampIn), .refNumIn(refNumIn),
        .buySellIn(buySellIn), .sharesIn(sharesIn), .stockIn(stockIn),
        .priceIn(priceIn), .matchNumIn(matchNumIn),
        .dataOut(dataOut), .dataValidOut(dataValidOut),
        .multiReqOut(multiReqOut)
    );

    always #2 clkIn = ~clkIn;

    // gapk: 0 = follows previous byte directly, 1 = exactly IPG low cycles,
    // 2 = at least IPG low cycles (packet started from idle)
    typedef struct {
        logic [7:0] b;
        bit         first;
        int         gapk;
    } eb_t;

    eb_t        expq[$];
    logic [7:0] seen[$];
    int nvec = 0, nerr = 0;
    int low_run = IPG, mpkt = 0, n_split = 0, split_pos = 0;
    bit exp_multi = 0, nxt_first = 0;
    int nxt_gapk = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            eb_t x;
            x.b = 8'(v >> (8 * i));
            x.first = nxt_first;
            x.gapk = nxt_gapk;
            nxt_first = 0;
            expq.push_back(x);
        end
    endtask

    // Reference: winning message bytes and where packet boundaries fall.
    task automatic model_accept(input bit a, input bit d, input bit e);
        int kind, len;
        bit chained;
        kind = a ? 0 : (d ? 1 : 2);
        len = (kind == 0 ? 36 : (kind == 1 ? 19 : 31)) + PFX;
        chained = (expq.size() != 0);
        if (chained && (mpkt + len <= MAXP)) begin
            nxt_gapk = 0;
            mpkt += len;
        end else begin
            nxt_gapk = chained ? 1 : 2;
            mpkt = len;
        end
        exp_multi = (int'(a) + int'(d) + int'(e)) > 1;
        nxt_first = 1;
        if (PFX != 0) put(64'(len), 2);
        put(kind == 0 ? 64'h41 : (kind == 1 ? 64'h44 : 64'h45), 1);
        put(64'(locateIn), 2);
        put(64'(trackNumIn), 2);
        put(64'(timeStampIn), 6);
        put(refNumIn, 8);
        if (kind == 0) begin
            put(buySellIn ? 64'h42 : 64'h53, 1);
            put(64'(sharesIn), 4);
            put(stockIn, 8);
            put(64'(priceIn), 4);
        end else if (kind == 2) begin
            put(64'(sharesIn), 4);
            put(matchNumIn, 8);
        end
    endtask

    task automatic monitor();
        eb_t e;
        if (dataValidOut) begin
            if (low_run > 0 && seen.size() > 0) begin
                n_split++;
                split_pos = seen.size();
            end
            seen.push_back(dataOut);
            if (expq.size() == 0) begin
                chk("extra_byte", dataValidOut, 0);
            end else begin
                e = expq.pop_front();
                chk("byte", dataOut, e.b);
                if (e.first) begin
                    if (e.gapk == 0) chk("b2b_gap", low_run, 0);
                    else if (e.gapk == 1) chk("ipg_gap", low_run, IPG);
                    else chk("idle_gap", low_run >= IPG, 1);
                end
            end
            low_run = 0;
        end else begin
            chk("zero_out", dataOut, 0);
            low_run++;
        end
        chk("multi", multiReqOut, exp_multi);
        exp_multi = 0;
        if (expq.size() > 0) chk("ready", readyOut, expq.size() == 1);
    endtask

    task automatic tick();
        @(negedge clkIn);
        monitor();
    endtask

    task automatic rand_fields();
        locateIn = 16'($urandom);
        trackNumIn = 16'($urandom);
        timeStampIn = {16'($urandom), $urandom};
        refNumIn = {$urandom, $urandom};
        buySellIn = 1'($urandom);
        sharesIn = $urandom;
        stockIn = {$urandom, $urandom};
        priceIn = $urandom;
        matchNumIn = {$urandom, $urandom};
    endtask

    task automatic step(input bit a, input bit d, input bit e,
                        input bit keep, output bit acc);
        if (!keep) rand_fields();
        addValidIn = a;
        delValidIn = d;
        execValidIn = e;
        acc = readyOut && (a || d || e);
        if (acc) model_accept(a, d, e);
    endtask

    task automatic send(input bit a, input bit d, input bit e, input bit keep);
        bit acc = 0;
        int n = 0;
        while (!acc && n < 200) begin
            step(a, d, e, keep, acc);
            tick();
            n++;
        end
        addValidIn = 0;
        delValidIn = 0;
        execValidIn = 0;
        chk("accept_wait", acc, 1);
    endtask

    task automatic drain();
        int n = 0;
        addValidIn = 0;
        delValidIn = 0;
        execValidIn = 0;
        while (expq.size() > 0 && n < 5000) begin
            tick();
            n++;
        end
        chk("drain", expq.size(), 0);
        repeat (IPG + 2) tick();
    endtask

    initial begin
        bit acc;
        int n;
        // reset values
        repeat (3) tick();
        chk("rst_data", dataOut, 0);
        chk("rst_valid", dataValidOut, 0);
        chk("rst_ready", readyOut, 1);
        chk("rst_multi", multiReqOut, 0);
        rstIn = 0;
        low_run = IPG;
        repeat (2) tick();

        // directed Add with latency check
        seen.delete();
        locateIn = 16'hBE42;
        trackNumIn = 16'h0001;
        timeStampIn = 48'h000000000455;
        refNumIn = 64'hDEFB1673DEFB1673;
        buySellIn = 1;
        sharesIn = 32'h45;
        stockIn = 64'h4141504C20202020;
        priceIn = 32'h0022FEFC;
        send(1, 0, 0, 1);
        chk("lat_n", dataValidOut, 0);
        tick();
        chk("lat_n1", dataValidOut, 1);
        chk("lat_b0", dataOut, PFX != 0 ? 8'h00 : 8'h41);
        drain();
        chk("add_len", seen.size(), 36 + PFX);
        if (seen.size() == 36 + PFX) begin
            chk("add_type", seen[PFX], 8'h41);
            chk("add_buy", seen[19 + PFX], 8'h42);
            chk("add_last", seen[35 + PFX], 8'hFC);
        end

        // Delete then Executed chained
        seen.delete();
        n_split = 0;
        refNumIn = 64'hDEF12373DEFDE89C;
        send(0, 1, 0, 1);
        sharesIn = 32'hABCD7684;
        matchNumIn = 64'h3BD786555512BED7;
        send(0, 0, 1, 1);
        drain();
        chk("de_len", seen.size(), 50 + 2 * PFX);
        chk("de_split", n_split, 0);
        if (seen.size() == 50 + 2 * PFX) begin
            chk("del_last", seen[18 + PFX], 8'h9C);
            chk("exe_type", seen[19 + 2 * PFX], 8'h45);
`ifdef ITCH_LEN_PREFIX_EN
            chk("pfx_hi", seen[0], 8'h00);
            chk("pfx_lo", seen[1], 8'h13);
            chk("pfx_type", seen[2], 8'h44);
`endif
        end

        // Add and Executed together: Add wins, Executed dropped
        seen.delete();
        send(1, 0, 1, 0);
        drain();
        chk("multi_len", seen.size(), 36 + PFX);

        // triplet streaming to force a packet split
        seen.delete();
        n_split = 0;
        for (int t = 0; t < 17; t++) begin
            send(1, 0, 0, 0);
            send(0, 1, 0, 0);
            send(0, 0, 1, 0);
        end
        drain();
        chk("trip_bytes", seen.size(), 17 * (86 + 3 * PFX));
        chk("trip_splits", n_split, 1);
        chk("trip_split_at", split_pos, PFX != 0 ? 1380 : 1376);
        chk("trip_after", seen[split_pos], PFX != 0 ? 8'h00 : 8'h41);

        // reset mid Add at byte 10
        seen.delete();
        send(1, 0, 0, 0);
        n = 0;
        while (seen.size() < 11 && n < 100) begin
            tick();
            n++;
        end
        chk("rst_wait", seen.size(), 11);
        rstIn = 1;
        expq.delete();
        mpkt = 0;
        tick();
        chk("mid_rst_valid", dataValidOut, 0);
        chk("mid_rst_ready", readyOut, 1);
        rstIn = 0;
        low_run = IPG;
        seen.delete();
        send(0, 1, 0, 0);
        drain();
        chk("post_rst_del", seen.size(), 19 + PFX);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int v;
            v = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 7);
            step(v[2], v[1], v[0], 0, acc);
            tick();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/itch_msg_builder.md
# itch_msg_builder

Transmit-side counterpart of `itch_parser`. Accepts one decoded ITCH 5.0 order event per handshake: Add, Order Delete or Order Executed. Serializes each event MSB-first into the byte stream `itch_parser` consumes (`dataOut`/`dataValidOut`). Packs messages back-to-back into packets and drops `dataValidOut` for an inter-packet gap whenever a packet closes. Used for hardware loopback of the parser and as a synthesizable replay/stimulus source.

## Interface
Parameters:
- `MAX_PKT_BYTES`, 1400: maximum ITCH bytes per packet (prefixes included); range 36..2047.
- `IPG_CYCLES`, 12: cycles `dataValidOut` is held low between packets; minimum 1.

Ports (all `*In` sampled and all `*Out` driven on rising `clkIn`):
- `clkIn`  in  1  single clock (250 MHz).
- `rstIn`  in  1  synchronous, active-high reset.
- `addValidIn`  in  1  request to send an Add ('A', 0x41).
- `delValidIn`  in  1  request to send an Order Delete ('D', 0x44).
- `execValidIn`  in  1  request to send an Order Executed ('E', 0x45).
- `readyOut`  out  1  builder can accept a request this cycle.
- `locateIn`  in  16  stock locate.
- `trackNumIn`  in  16  tracking number.
- `timeStampIn`  in  48  timestamp.
- `refNumIn`  in  64  order reference number.
- `buySellIn`  in  1  1 = buy ('B', 0x42), 0 = sell ('S', 0x53). Add only.
- `sharesIn`  in  32  shares (Add) or executed shares (Executed).
- `stockIn`  in  64  8-char ASCII, space padded. Add only.
- `priceIn`  in  32  price in $0.0001 units. Add only.
- `matchNumIn`  in  64  match number. Executed only.
- `dataOut`  out  8  serialized byte.
- `dataValidOut`  out  1  byte valid; low marks a packet boundary.
- `multiReqOut`  out  1  one-cycle pulse: more than one `*ValidIn` was high on an accepted cycle.

## Operation
- Accept occurs when any `*ValidIn` is high and `readyOut` is high. All fields are captured into holding registers. Inputs are don't-care after the accept cycle.
- When several valids are high: priority Add > Delete > Executed. The lower-priority requests are dropped and `multiReqOut` pulses.
- Message layouts (all fields big-endian):
  - Add, 36 B: type, locate, trackNum, timeStamp, refNum, buySell, shares, stock, price.
  - Delete, 19 B: type, locate, trackNum, timeStamp, refNum.
  - Executed, 31 B: type, locate, trackNum, timeStamp, refNum, shares, matchNum.
- States:
  - IDLE: `readyOut`=1, `dataValidOut`=0. Accept → SEND.
  - SEND: emit one byte per cycle. `readyOut`=1 only on the last byte of the message. Transitions at the last byte:
    - Accept that fits (`pktBytes`+len ≤ `MAX_PKT_BYTES`) → SEND the next message with no bubble.
    - Accept that would overflow → GAP with `pending`=1.
    - No accept → GAP with `pending`=0.
  - GAP: `dataValidOut`=0, `readyOut`=0 for exactly `IPG_CYCLES` cycles. Then go to SEND if `pending`, otherwise IDLE.
- `pktBytes` (11 bit) counts bytes emitted in the current packet and clears on entry to GAP. A single message never overflows an empty packet.
- `dataOut` is 0x00 whenever `dataValidOut`=0.

## Timing
- Reset values: `dataOut`=0x00, `dataValidOut`=0, `readyOut`=1, `multiReqOut`=0. State = IDLE; `pktBytes`, `pending` and the byte counter are cleared.
- Accept on edge N → byte 0 (the type byte) is on `dataOut` after edge N+1. A message of L bytes occupies cycles N+1..N+L.
- Back-to-back accept on the last-byte cycle → the next type byte follows immediately, with zero idle cycles.
- `readyOut` depends only on registered state; there is no combinational path from valid to ready.
- `rstIn` asserted mid-message aborts the message. Outputs reach reset values on the next edge. No truncated byte is emitted after that edge.

## Configuration
- `ITCH_LEN_PREFIX_EN` defined:
  - Each message is preceded by a 2-byte big-endian length: 0x0024 for Add, 0x0013 for Delete, 0x001F for Executed. This is MoldUDP64 message-block framing.
  - L grows by 2 and the 2 bytes count toward `pktBytes`.
  - Type-byte latency becomes N+3.
- Not defined: no prefix; the message starts with its type byte.

## Test plan
- Add: locate 0xBE42, track 0x0001, ts 0x000000000455, ref 0xDEFB1673DEFB1673, buy, shares 0x45, stock 0x4141504C20202020 ("AAPL"), price 0x0022FEFC.
  → 36 bytes `41 BE 42 00 01 00 00 00 00 04 55 DE FB 16 73 DE FB 16 73 42 00 00 00 45 41 41 50 4C 20 20 20 20 00 22 FE FC`, first byte at N+1.
- Delete ref 0xDEF12373DEFDE89C, then Executed (shares 0xABCD7684, match 0x3BD786555512BED7) accepted on the Delete's last byte.
  → 50 contiguous valid bytes. The byte after 0x9C is 0x45.
- Repeat Add/Delete/Executed (86 B per triplet) continuously with `MAX_PKT_BYTES`=1400.
  → After 1376 B (16 triplets, ending on an Executed), `dataValidOut` is low for exactly 12 cycles, then a new packet starts with 0x41. Looping the output into `itch_parser` decodes every message.
- `addValidIn` and `execValidIn` high together.
  → An Add is sent, `multiReqOut` pulses 1 cycle, and the Executed request is dropped.
- `rstIn` asserted at byte 10 of an Add.
  → `dataValidOut`=0 and `readyOut`=1 next cycle. A subsequent Delete is sent intact.
- `ITCH_LEN_PREFIX_EN` defined, single Delete.
  → Stream is `00 13 44 …`, 21 bytes.
